// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, ALU function codes,
// branch/move condition codes, the "no register" ID and cc bit positions.
package y86_pkg;

    // Instruction codes (icode field)
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;  // also CMOVXX, qualified by ifun
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // ALU function codes (low two bits of ifun for OPq)
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    // Condition codes (ifun for CMOVXX / JXX)
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Register ID meaning "no register"
    localparam logic [3:0] RNONE = 4'hF;

    // Bit positions inside the 3-bit cc vector {ZF,SF,OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    // Condition code value out of reset: ZF=1, SF=0, OF=0
    localparam logic [2:0] CC_RESET = 3'b100;

    // Evaluate a move/branch condition against a cc snapshot.
    function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] ifun);
        logic zf;
        logic sf;
        logic of;
        logic res;
        zf = cc[CC_ZF];
        sf = cc[CC_SF];
        of = cc[CC_OF];
        case (ifun)
            C_YES:   res = 1'b1;
            C_LE:    res = (sf ^ of) | zf;
            C_L:     res = sf ^ of;
            C_E:     res = zf;
            C_NE:    res = ~zf;
            C_GE:    res = ~(sf ^ of);
            C_G:     res = ~(sf ^ of) & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational Y86-64 ALU: add, sub (a-b), and, xor, with signed overflow.
module execute_stage_alu
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [1:0]   i_fun,
    output logic [W-1:0] o_result,
    output logic         o_of
);

    // Compute result and overflow; overflow only has meaning for add/sub.
    always_comb begin
        o_result = '0;
        o_of     = 1'b0;
        case (i_fun)
            ALU_ADD: begin
                o_result = i_a + i_b;
                o_of     = (i_a[W-1] == i_b[W-1]) && (o_result[W-1] != i_a[W-1]);
            end
            ALU_SUB: begin
                o_result = i_a - i_b;
                o_of     = (i_a[W-1] != i_b[W-1]) && (o_result[W-1] != i_a[W-1]);
            end
            ALU_AND: o_result = i_a & i_b;
            default: o_result = i_a ^ i_b;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: one-cycle registered ALU stage with condition codes,
// CMOV/JXX condition evaluation, flush squash and valid/ready flow control.
//
// Handshake: a transfer happens on a rising edge where valid && ready is
// high on that side. in_ready = !out_valid || out_ready, so the single output
// register accepts new work whenever it is empty or being drained this cycle;
// while out_valid && !out_ready every e_* output is frozen.
module execute_stage #(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   d_icode,
    input  logic [3:0]   d_ifun,
    input  logic [W-1:0] d_valA,
    input  logic [W-1:0] d_valB,
    input  logic [W-1:0] d_valC,
    input  logic [3:0]   d_dstE,
    input  logic [3:0]   d_dstM,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   e_icode,
    output logic [W-1:0] e_valE,
    output logic [W-1:0] e_valA,
    output logic [3:0]   e_dstE,
    output logic [3:0]   e_dstM,
    output logic         e_cnd,
    output logic [2:0]   cc
);
    import y86_pkg::*;

    localparam logic [W-1:0] STACK_STEP     = W'(8);
    localparam logic [W-1:0] STACK_STEP_NEG = ~STACK_STEP + W'(1);

    logic [W-1:0] w_alu_a;
    logic [W-1:0] w_alu_b;
    logic [1:0]   w_alu_fun;
    logic [W-1:0] w_alu_res;
    logic         w_alu_of;
    logic         w_transfer;
    logic         w_cnd;
    logic [3:0]   w_dstE;
    logic [2:0]   w_new_cc;

    logic         r_out_valid;
    logic [3:0]   r_icode;
    logic [W-1:0] r_valE;
    logic [W-1:0] r_valA;
    logic [3:0]   r_dstE;
    logic [3:0]   r_dstM;
    logic         r_cnd;
    logic [2:0]   r_cc;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_transfer = in_valid && in_ready;

    // Select ALU operands and function from the instruction class.
    always_comb begin
        w_alu_a   = '0;
        w_alu_b   = '0;
        w_alu_fun = ALU_ADD;
        case (d_icode)
            I_OPQ: begin
                w_alu_a   = d_valB;
                w_alu_b   = d_valA;
                w_alu_fun = d_ifun[1:0];
            end
            I_RRMOVQ: w_alu_b = d_valA;
            I_IRMOVQ: w_alu_b = d_valC;
            I_RMMOVQ, I_MRMOVQ: begin
                w_alu_a = d_valB;
                w_alu_b = d_valC;
            end
            I_PUSHQ, I_CALL: begin
                w_alu_a = d_valB;
                w_alu_b = STACK_STEP_NEG;
            end
            I_POPQ, I_RET: begin
                w_alu_a = d_valB;
                w_alu_b = STACK_STEP;
            end
            default: ;
        endcase
    end

    execute_stage_alu #(
        .W(W)
    ) u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_fun    (w_alu_fun),
        .o_result (w_alu_res),
        .o_of     (w_alu_of)
    );

    // Evaluate CMOV/JXX condition against the cc held before this edge and
    // cancel the register write of a CMOV whose condition fails.
    always_comb begin
        w_cnd  = 1'b1;
        w_dstE = d_dstE;
        if (d_icode == I_RRMOVQ || d_icode == I_JXX) begin
            w_cnd = cond_eval(r_cc, d_ifun);
        end
        if (d_icode == I_RRMOVQ && !w_cnd) begin
            w_dstE = RNONE;
        end
    end

    assign w_new_cc = {(w_alu_res == '0), w_alu_res[W-1], w_alu_of};

    // Output pipeline register: flush squashes, transfer loads, drain empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_icode     <= I_NOP;
            r_valE      <= '0;
            r_valA      <= '0;
            r_dstE      <= RNONE;
            r_dstM      <= RNONE;
            r_cnd       <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_icode     <= I_NOP;
            r_dstE      <= RNONE;
            r_dstM      <= RNONE;
        end else if (w_transfer) begin
            r_out_valid <= 1'b1;
            r_icode     <= d_icode;
            r_valE      <= w_alu_res;
            r_valA      <= d_valA;
            r_dstE      <= w_dstE;
            r_dstM      <= d_dstM;
            r_cnd       <= w_cnd;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Condition codes change only when an OPq is actually accepted and not squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= CC_RESET;
        end else if (w_transfer && !flush && d_icode == I_OPQ) begin
            r_cc <= w_new_cc;
        end
    end

    assign out_valid = r_out_valid;
    assign e_icode   = r_icode;
    assign e_valE    = r_valE;
    assign e_valA    = r_valA;
    assign e_dstE    = r_dstE;
    assign e_dstM    = r_dstM;
    assign e_cnd     = r_cnd;
    assign cc        = r_cc;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed instructions push their
// hand-computed results; a monitor pops and compares on every output transfer.
module tb_execute_stage;

    localparam int W = 64;

    typedef struct packed {
        logic [3:0]   icode;
        logic [W-1:0] valE;
        logic [W-1:0] valA;
        logic [3:0]   dstE;
        logic [3:0]   dstM;
        logic         cnd;
        logic [2:0]   cc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   d_icode;
    logic [3:0]   d_ifun;
    logic [W-1:0] d_valA;
    logic [W-1:0] d_valB;
    logic [W-1:0] d_valC;
    logic [3:0]   d_dstE;
    logic [3:0]   d_dstM;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   e_icode;
    logic [W-1:0] e_valE;
    logic [W-1:0] e_valA;
    logic [3:0]   e_dstE;
    logic [3:0]   e_dstM;
    logic         e_cnd;
    logic [2:0]   cc;

    exp_t exp_q[$];
    int   n_compared;
    int   n_mismatched;
    int   n_out;

    execute_stage #(
        .W(W),
        .RNONE(4'hF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_icode   (d_icode),
        .d_ifun    (d_ifun),
        .d_valA    (d_valA),
        .d_valB    (d_valB),
        .d_valC    (d_valC),
        .d_dstE    (d_dstE),
        .d_dstM    (d_dstM),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .e_icode   (e_icode),
        .e_valE    (e_valE),
        .e_valA    (e_valA),
        .e_dstE    (e_dstE),
        .e_dstM    (e_dstM),
        .e_cnd     (e_cnd),
        .cc        (cc)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " out_valid"}, W'(out_valid), W'(0));
        check({tag, " cc"},        W'(cc),        W'(3'b100));
        check({tag, " e_icode"},   W'(e_icode),   W'(4'h1));
        check({tag, " e_valE"},    e_valE,        W'(0));
        check({tag, " e_valA"},    e_valA,        W'(0));
        check({tag, " e_dstE"},    W'(e_dstE),    W'(4'hF));
        check({tag, " e_dstM"},    W'(e_dstM),    W'(4'hF));
        check({tag, " e_cnd"},     W'(e_cnd),     W'(0));
        check({tag, " in_ready"},  W'(in_ready),  W'(1));
    endtask

    // Monitor: a negedge with out_valid && out_ready means the next edge moves this result out.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            n_out++;
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL unexpected_output: got icode 0x%0h valE 0x%0h with empty queue", e_icode, e_valE);
            end else begin
                e = exp_q.pop_front();
                check("e_icode", W'(e_icode), W'(e.icode));
                check("e_valE",  e_valE,      e.valE);
                check("e_valA",  e_valA,      e.valA);
                check("e_dstE",  W'(e_dstE),  W'(e.dstE));
                check("e_dstM",  W'(e_dstM),  W'(e.dstM));
                check("e_cnd",   W'(e_cnd),   W'(e.cnd));
                check("cc",      W'(cc),      W'(e.cc));
            end
        end
    end

    // Driver: present one instruction, wait (bounded) for in_ready, transfer on the next edge.
    task automatic send(input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vc,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic fl, input logic push_exp, input exp_t e);
        int n;
        d_icode  = icode;
        d_ifun   = ifun;
        d_valA   = va;
        d_valB   = vb;
        d_valC   = vc;
        d_dstE   = de;
        d_dstM   = dm;
        flush    = fl;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        if (push_exp) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [3:0] icode, input logic [W-1:0] valE, input logic [W-1:0] valA,
                                input logic [3:0] dstE, input logic [3:0] dstM, input logic cnd,
                                input logic [2:0] ccv);
        exp_t e;
        e.icode = icode;
        e.valE  = valE;
        e.valA  = valA;
        e.dstE  = dstE;
        e.dstM  = dstM;
        e.cnd   = cnd;
        e.cc    = ccv;
        return e;
    endfunction

    initial begin
        int out_before;
        exp_t none;
        none         = '0;
        n_compared   = 0;
        n_mismatched = 0;
        n_out        = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        d_icode   = 4'h1;
        d_ifun    = 4'h0;
        d_valA    = '0;
        d_valB    = '0;
        d_valC    = '0;
        d_dstE    = 4'hF;
        d_dstM    = 4'hF;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // OPq sub 5-5: zero result, ZF set, visible one edge after transfer
        send(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 4'hF, 1'b0, 1'b1,
             mk(4'h6, 64'd0, 64'd5, 4'h2, 4'hF, 1'b1, 3'b100));
        check("latency out_valid", W'(out_valid), W'(1));
        check("latency e_valE", e_valE, W'(0));

        // OPq add overflow, then JXX l sees SF=1 OF=1 -> not taken
        send(4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0, 4'h3, 4'hF, 1'b0, 1'b1,
             mk(4'h6, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 4'h3, 4'hF, 1'b1, 3'b011));
        send(4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF, 1'b0, 1'b1,
             mk(4'h7, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 3'b011));
        // CMOV e with ZF=0: write cancelled
        send(4'h2, 4'h3, 64'h1234, 64'd0, 64'd0, 4'h3, 4'hF, 1'b0, 1'b1,
             mk(4'h2, 64'h1234, 64'h1234, 4'hF, 4'hF, 1'b0, 3'b011));
        // CMOV ne with ZF=0: write kept
        send(4'h2, 4'h4, 64'h55, 64'd0, 64'd0, 4'h4, 4'hF, 1'b0, 1'b1,
             mk(4'h2, 64'h55, 64'h55, 4'h4, 4'hF, 1'b1, 3'b011));
        // IRMOVQ
        send(4'h3, 4'h0, 64'd0, 64'd0, 64'h77, 4'h5, 4'hF, 1'b0, 1'b1,
             mk(4'h3, 64'h77, 64'd0, 4'h5, 4'hF, 1'b1, 3'b011));
        // MRMOVQ address valB+valC
        send(4'h5, 4'h0, 64'd0, 64'h10, 64'h8, 4'hF, 4'h6, 1'b0, 1'b1,
             mk(4'h5, 64'h18, 64'd0, 4'hF, 4'h6, 1'b1, 3'b011));
        // OPq and: clears OF
        send(4'h6, 4'h2, 64'h3C, 64'hF0, 64'd0, 4'h1, 4'hF, 1'b0, 1'b1,
             mk(4'h6, 64'h30, 64'h3C, 4'h1, 4'hF, 1'b1, 3'b000));
        // OPq xor: all ones, SF set
        send(4'h6, 4'h3, 64'd0, {W{1'b1}}, 64'd0, 4'h2, 4'hF, 1'b0, 1'b1,
             mk(4'h6, {W{1'b1}}, 64'd0, 4'h2, 4'hF, 1'b1, 3'b010));
        // POPQ valB+8
        send(4'hB, 4'h0, 64'h100, 64'h100, 64'd0, 4'h4, 4'h0, 1'b0, 1'b1,
             mk(4'hB, 64'h108, 64'h100, 4'h4, 4'h0, 1'b1, 3'b010));

        // PUSHQ under a 3-cycle stall
        idle(2);
        out_ready  = 1'b0;
        out_before = n_out;
        send(4'hA, 4'h0, 64'hAB, 64'h100, 64'd0, 4'h4, 4'hF, 1'b0, 1'b1,
             mk(4'hA, 64'hF8, 64'hAB, 4'h4, 4'hF, 1'b1, 3'b010));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall out_valid", W'(out_valid), W'(1));
            check("stall e_valE", e_valE, W'(64'hF8));
            check("stall in_ready", W'(in_ready), W'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("drain out_valid", W'(out_valid), W'(0));
        check("stall transfers out", W'(n_out - out_before), W'(1));

        // Flushed OPq: squashed output, cc untouched
        send(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h3, 4'h2, 1'b1, 1'b0, none);
        check("flush out_valid", W'(out_valid), W'(0));
        check("flush cc", W'(cc), W'(3'b010));
        check("flush e_icode", W'(e_icode), W'(4'h1));
        check("flush e_dstE", W'(e_dstE), W'(4'hF));
        check("flush e_dstM", W'(e_dstM), W'(4'hF));

        // Reset pulsed mid-stall: outputs clear without a clock edge
        out_ready = 1'b0;
        send(4'h6, 4'h0, 64'd2, 64'd3, 64'd0, 4'h7, 4'hF, 1'b0, 1'b0, none);
        @(negedge clk);
        check("midstall in_ready", W'(in_ready), W'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Post-reset OPq sub 3-5: negative, no overflow
        send(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h1, 4'hF, 1'b0, 1'b1,
             mk(4'h6, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 4'h1, 4'hF, 1'b1, 3'b010));

        idle(4);
        check("queue drained", W'(exp_q.size()), W'(0));
        check("total transfers out", W'(n_out), W'(12));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Global time limit
    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
